// File: rtl/seq_detector_param.sv
// Serial pattern detector with selectable overlap mode.
// Bits are shifted in MSB-first whenever en is high. A match raises detect
// for one cycle and bumps a saturating match counter. In non-overlap mode
// the valid-bit fill count restarts after a match, so no matched bit is reused.
module seq_detector_param #(
  parameter int PAT_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic               in,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               detect,
  output logic [CNT_W-1:0]   count
);

  localparam logic [4:0] LEN5 = 5'(PAT_LEN);

  logic [PAT_LEN-1:0] r_hist;
  logic [4:0]         r_fill;
  logic               r_detect;
  logic [CNT_W-1:0]   r_count;

  logic [PAT_LEN-1:0] w_hist_n;
  logic [4:0]         w_fill_n;
  logic               w_match;

  // Next history, saturating fill and match against the live pattern.
  always_comb begin
    w_hist_n = {r_hist[PAT_LEN-2:0], in};
    w_fill_n = (r_fill >= LEN5) ? LEN5 : r_fill + 5'd1;
    w_match  = (w_fill_n == LEN5) && (w_hist_n == pattern);
  end

  // State update: async reset, then clear, then hold or sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist   <= '0;
      r_fill   <= '0;
      r_detect <= 1'b0;
      r_count  <= '0;
    end else if (clear) begin
      r_hist   <= '0;
      r_fill   <= '0;
      r_detect <= 1'b0;
      r_count  <= '0;
    end else if (!en) begin
      r_detect <= 1'b0;
    end else begin
      r_hist   <= w_hist_n;
      r_detect <= w_match;
      if (w_match) begin
        if (r_count != '1) begin
          r_count <= r_count + 1'b1;
        end
        r_fill <= overlap ? w_fill_n : '0;
      end else begin
        r_fill <= w_fill_n;
      end
    end
  end

  assign detect = r_detect;
  assign count  = r_count;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: three instances (3-bit/8-bit count,
// 4-bit/8-bit count, 3-bit/2-bit count) share the serial stream; a behavioural
// model queues expected detect/count per instance on every driven cycle.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, en, clear, in, overlap;
  logic [2:0] pat3, pats;
  logic [3:0] pat4;
  logic       d3, d4, ds;
  logic [7:0] c3, c4;
  logic [1:0] cs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int k;
    int det;
    int cnt;
  } exp_t;
  exp_t sb[$];

  int m_hist[3];
  int m_fill[3];
  int m_cnt[3];
  int m_det[3];
  int tally[3];

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_LEN(3), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .in(in),
    .pattern(pat3), .overlap(overlap), .detect(d3), .count(c3));

  seq_detector_param #(.PAT_LEN(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .in(in),
    .pattern(pat4), .overlap(overlap), .detect(d4), .count(c4));

  seq_detector_param #(.PAT_LEN(3), .CNT_W(2)) us (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .in(in),
    .pattern(pats), .overlap(overlap), .detect(ds), .count(cs));

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int act_det(input int k);
    case (k)
      0:       return int'(d3);
      1:       return int'(d4);
      default: return int'(ds);
    endcase
  endfunction

  function automatic int act_cnt(input int k);
    case (k)
      0:       return int'(c3);
      1:       return int'(c4);
      default: return int'(cs);
    endcase
  endfunction

  task automatic model_clear(input int k);
    m_hist[k] = 0;
    m_fill[k] = 0;
    m_cnt[k]  = 0;
    m_det[k]  = 0;
  endtask

  task automatic model_step(input int k, input int len, input int cmax, input int pat,
                            input bit ov, input bit c, input bit e, input bit b);
    int mask, hn, fn;
    bit hit;
    mask = (1 << len) - 1;
    if (c) begin
      model_clear(k);
    end else if (!e) begin
      m_det[k] = 0;
    end else begin
      hn  = ((m_hist[k] << 1) | int'(b)) & mask;
      fn  = (m_fill[k] < len) ? m_fill[k] + 1 : len;
      hit = (fn == len) && (hn == (pat & mask));
      m_det[k]  = int'(hit);
      m_hist[k] = hn;
      if (hit) begin
        if (m_cnt[k] < cmax) m_cnt[k]++;
        m_fill[k] = ov ? fn : 0;
      end else begin
        m_fill[k] = fn;
      end
    end
  endtask

  // One sampling cycle: drive at negedge, queue expectations, compare after posedge.
  task automatic cyc(input bit e, input bit c, input bit b);
    exp_t x;
    @(negedge clk);
    en = e; clear = c; in = b;
    model_step(0, 3, 255, int'(pat3), overlap, c, e, b);
    model_step(1, 4, 255, int'(pat4), overlap, c, e, b);
    model_step(2, 3, 3,   int'(pats), overlap, c, e, b);
    for (int k = 0; k < 3; k++) sb.push_back('{k: k, det: m_det[k], cnt: m_cnt[k]});
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check($sformatf("det%0d", x.k), act_det(x.k), x.det);
      check($sformatf("cnt%0d", x.k), act_cnt(x.k), x.cnt);
      if (act_det(x.k) == 1) tally[x.k]++;
    end
  endtask

  task automatic stream(input logic [15:0] v, input int n);
    logic [15:0] t;
    t = v;
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, 1'b0, t[i]);
  endtask

  task automatic restart();
    cyc(1'b1, 1'b1, 1'b1);
    check("clr_det", int'(d3), 0);
    check("clr_cnt", int'(c3), 0);
    for (int k = 0; k < 3; k++) tally[k] = 0;
  endtask

  // Called at posedge+1: pulse reset low between edges and release before the next negedge.
  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    check("rst_d3", int'(d3), 0);
    check("rst_c3", int'(c3), 0);
    check("rst_d4", int'(d4), 0);
    check("rst_c4", int'(c4), 0);
    check("rst_ds", int'(ds), 0);
    check("rst_cs", int'(cs), 0);
    for (int k = 0; k < 3; k++) model_clear(k);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; clear = 1'b0; in = 1'b0; overlap = 1'b0;
    pat3 = 3'b101; pat4 = 4'b1101; pats = 3'b111;
    for (int k = 0; k < 3; k++) begin
      model_clear(k);
      tally[k] = 0;
    end
    #3;
    check("reset_d3", int'(d3), 0);
    check("reset_c3", int'(c3), 0);
    check("reset_cs", int'(cs), 0);
    #1;
    rst = 1'b1;

    // 101 non-overlap over 1,0,1,0,1
    overlap = 1'b0;
    restart();
    stream(16'b10101, 5);
    check("no_ov_pulses", tally[0], 1);
    check("no_ov_count", int'(c3), 1);

    // same stream with overlap
    overlap = 1'b1;
    restart();
    stream(16'b10101, 5);
    check("ov_pulses", tally[0], 2);
    check("ov_count", int'(c3), 2);

    // 1101 over 1,1,0,1,1,0,1 in both modes
    restart();
    stream(16'b1101101, 7);
    check("p4_ov_pulses", tally[1], 2);
    overlap = 1'b0;
    restart();
    stream(16'b1101101, 7);
    check("p4_noov_pulses", tally[1], 1);
    check("p4_noov_count", int'(c4), 1);

    // enable gap does not sample
    restart();
    stream(16'b10, 2);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("gap_pulses", tally[0], 0);
    cyc(1'b1, 1'b0, 1'b1);
    check("gap_hit", int'(d3), 1);
    check("gap_total", tally[0], 1);

    // saturation with an all-ones pattern
    overlap = 1'b1;
    restart();
    stream(16'hFF, 8);
    check("sat_pulses", tally[2], 6);
    check("sat_count", int'(cs), 3);

    // reset mid-sequence discards partial match
    pat3 = 3'b101;
    restart();
    stream(16'b10, 2);
    pulse_reset();
    cyc(1'b1, 1'b0, 1'b1);
    check("rst_nohit", tally[0], 0);

    // randomised stream with live pattern/overlap changes, clears and resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) overlap = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) pat3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) pat4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) pats = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) pulse_reset();
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
